// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage PC controller.
// Holds the PC width and reset value, the run/halt state encoding and the next-PC source codes.
package pc_fetch_ctrl_pkg;

   localparam int              PC_W     = 6;
   localparam logic [PC_W-1:0] RESET_PC = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NPC_HOLD = 2'd0,
      NPC_INC  = 2'd1,
      NPC_BR   = 2'd2,
      NPC_JMP  = 2'd3
   } npc_sel_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus of the PC controller: redirect/stall/halt requests in, PC and status out.
// The master side is the controller itself; the slave side is the surrounding pipeline.
interface pc_fetch_ctrl_if #(
   parameter int PC_W = pc_fetch_ctrl_pkg::PC_W
);
   logic [PC_W-1:0] pc_plus1;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            jump;
   logic [PC_W-1:0] jump_target;
   logic            stall;
   logic            halt;
   logic            resume;
   logic            imem_ready;
   logic [PC_W-1:0] pc_out;
   logic            fetch_valid;
   logic            halted;
   logic            pc_wrap;

   modport master (
      input  pc_plus1,
      input  branch_taken,
      input  branch_target,
      input  jump,
      input  jump_target,
      input  stall,
      input  halt,
      input  resume,
      input  imem_ready,
      output pc_out,
      output fetch_valid,
      output halted,
      output pc_wrap
   );

   modport slave (
      output pc_plus1,
      output branch_taken,
      output branch_target,
      output jump,
      output jump_target,
      output stall,
      output halt,
      output resume,
      output imem_ready,
      input  pc_out,
      input  fetch_valid,
      input  halted,
      input  pc_wrap
   );
endinterface

// File: rtl/pc_fetch_ctrl_pc_next_mux.sv
// Combinational next-PC priority select: halt > jump > branch > hold (stall/not ready) > increment.
// Outside RUN the PC always holds.
module pc_next_mux
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int PC_W = pc_fetch_ctrl_pkg::PC_W
) (
   input  logic            run,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] pc_plus1,
   input  logic            halt,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            stall,
   input  logic            imem_ready,
   output logic [PC_W-1:0] next_pc,
   output npc_sel_t        sel
);

   // Redirects bypass stall/imem_ready; only halt can drop them.
   always_comb begin
      sel = NPC_HOLD;
      if (run && !halt) begin
         if (jump) begin
            sel = NPC_JMP;
         end else if (branch_taken) begin
            sel = NPC_BR;
         end else if (!stall && imem_ready) begin
            sel = NPC_INC;
         end
      end
   end

   always_comb begin
      next_pc = pc;
      case (sel)
         NPC_INC:  next_pc = pc_plus1;
         NPC_BR:   next_pc = branch_target;
         NPC_JMP:  next_pc = jump_target;
         default:  next_pc = pc;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter with run/halt sequencing and a valid/ready fetch handshake.
// All outputs come straight from registers; there is no input-to-pc_out combinational path.
module pc_fetch_ctrl #(
   parameter int              PC_W     = pc_fetch_ctrl_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_PC = pc_fetch_ctrl_pkg::RESET_PC
) (
   input logic              clk,
   input logic              rst,
   pc_fetch_ctrl_if.master  bus
);
   import pc_fetch_ctrl_pkg::*;

   state_t          state_reg;
   state_t          state_next;
   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next;
   logic            wrap_reg;
   logic            wrap_next;
   npc_sel_t        npc_sel;
   logic            run;

   assign run = (state_reg == RUN);

   pc_next_mux #(
      .PC_W (PC_W)
   ) u_next_mux (
      .run           (run),
      .pc            (pc_reg),
      .pc_plus1      (bus.pc_plus1),
      .halt          (bus.halt),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .stall         (bus.stall),
      .imem_ready    (bus.imem_ready),
      .next_pc       (pc_next),
      .sel           (npc_sel)
   );

   // Halt together with resume keeps the controller parked.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: state_next = RUN;
         RUN:  if (bus.halt) state_next = HALT;
         HALT: if (bus.resume && !bus.halt) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // Only the increment path can wrap; a redirect to zero is not a wrap.
   assign wrap_next = (npc_sel == NPC_INC) && (pc_reg == {PC_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign bus.pc_out      = pc_reg;
   assign bus.fetch_valid = (state_reg == RUN);
   assign bus.halted      = (state_reg == HALT);
   assign bus.pc_wrap     = wrap_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations, then randomized
// stimulus, all checked every cycle against a behavioural model of the fetch controller.
module tb_pc_fetch_ctrl;

   localparam int PC_W = 6;
   localparam int MOD  = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

   pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(6'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // The PC adder in front of the controller.
   assign bus.pc_plus1 = bus.pc_out + 6'd1;

   // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
   int m_pc = 0, m_mode = 0, m_wrap = 0;
   int n_pc, n_mode, n_wrap;

   always_comb begin
      n_pc   = m_pc;
      n_mode = m_mode;
      n_wrap = 0;
      if (rst) begin
         n_pc   = 0;
         n_mode = 0;
      end else if (m_mode == 0) begin
         n_mode = 1;
      end else if (m_mode == 1) begin
         if (bus.halt)              n_mode = 2;
         else if (bus.jump)         n_pc = int'(bus.jump_target);
         else if (bus.branch_taken) n_pc = int'(bus.branch_target);
         else if (bus.imem_ready && !bus.stall) begin
            n_wrap = (m_pc == MOD - 1) ? 1 : 0;
            n_pc   = (m_pc + 1) % MOD;
         end
      end else begin
         if (bus.resume && !bus.halt) n_mode = 1;
      end
   end

   always @(posedge clk) begin
      m_pc   <= n_pc;
      m_mode <= n_mode;
      m_wrap <= n_wrap;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks += 4;
         if (int'(bus.pc_out) != m_pc) begin
            errors++;
            $display("FAIL model_pc t=%0t got %0d want %0d", $time, bus.pc_out, m_pc);
         end
         if (int'(bus.fetch_valid) != int'(m_mode == 1)) begin
            errors++;
            $display("FAIL model_fetch_valid t=%0t got %0d want %0d", $time, bus.fetch_valid, m_mode == 1);
         end
         if (int'(bus.halted) != int'(m_mode == 2)) begin
            errors++;
            $display("FAIL model_halted t=%0t got %0d want %0d", $time, bus.halted, m_mode == 2);
         end
         if (int'(bus.pc_wrap) != m_wrap) begin
            errors++;
            $display("FAIL model_pc_wrap t=%0t got %0d want %0d", $time, bus.pc_wrap, m_wrap);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.stall         = 1'b0;
      bus.halt          = 1'b0;
      bus.resume        = 1'b0;
      bus.imem_ready    = 1'b0;
   endtask

   task automatic jump_to(input int tgt);
      idle_inputs();
      bus.jump        = 1'b1;
      bus.jump_target = PC_W'(tgt);
      cyc();
      bus.jump = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      cyc();
      chk_en = 1'b1;
      // Reset then three accepted fetches: 0 (idle), 0, 1, 2.
      chk("rst_pc", int'(bus.pc_out), 0);
      chk("rst_fetch_valid", int'(bus.fetch_valid), 0);
      chk("rst_halted", int'(bus.halted), 0);
      chk("rst_pc_wrap", int'(bus.pc_wrap), 0);
      rst = 1'b0;
      bus.imem_ready = 1'b1;
      bus.halt = 1'b1;
      cyc();
      chk("idle_halt_ignored_fv", int'(bus.fetch_valid), 1);
      chk("run0_pc", int'(bus.pc_out), 0);
      bus.halt = 1'b0;
      cyc();
      chk("run1_pc", int'(bus.pc_out), 1);
      cyc();
      chk("run2_pc", int'(bus.pc_out), 2);

      // Not-ready and stall both hold the PC.
      jump_to(5);
      chk("jump5_pc", int'(bus.pc_out), 5);
      bus.imem_ready = 1'b0;
      cyc();
      chk("notready1_pc", int'(bus.pc_out), 5);
      cyc();
      chk("notready2_pc", int'(bus.pc_out), 5);
      bus.imem_ready = 1'b1;
      cyc();
      chk("ready_pc", int'(bus.pc_out), 6);
      bus.stall = 1'b1;
      cyc();
      chk("stall1_pc", int'(bus.pc_out), 6);
      cyc();
      chk("stall2_pc", int'(bus.pc_out), 6);
      bus.stall = 1'b0;
      cyc();
      chk("unstall_pc", int'(bus.pc_out), 7);

      // Jump beats branch and stall.
      jump_to(10);
      bus.jump = 1'b1; bus.jump_target = 6'd40;
      bus.branch_taken = 1'b1; bus.branch_target = 6'd20;
      bus.stall = 1'b1;
      cyc();
      chk("jump_priority_pc", int'(bus.pc_out), 40);
      bus.jump = 1'b0;
      cyc();
      chk("branch_over_stall_pc", int'(bus.pc_out), 20);

      // Wrap through the increment path only.
      jump_to(63);
      chk("pre_wrap_pc", int'(bus.pc_out), 63);
      bus.imem_ready = 1'b1;
      cyc();
      chk("wrap_pc", int'(bus.pc_out), 0);
      chk("wrap_pulse", int'(bus.pc_wrap), 1);
      bus.imem_ready = 1'b0;
      cyc();
      chk("wrap_pulse_end", int'(bus.pc_wrap), 0);
      jump_to(63);
      jump_to(0);
      chk("jump0_pc", int'(bus.pc_out), 0);
      chk("jump0_no_wrap", int'(bus.pc_wrap), 0);

      // Halt drops a simultaneous jump; jumps in halt are ignored; resume keeps PC.
      jump_to(7);
      bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 6'd20;
      cyc();
      chk("halt_pc", int'(bus.pc_out), 7);
      chk("halt_halted", int'(bus.halted), 1);
      chk("halt_fetch_valid", int'(bus.fetch_valid), 0);
      bus.halt = 1'b0; bus.imem_ready = 1'b1;
      cyc();
      chk("halt_jump_ignored_pc", int'(bus.pc_out), 7);
      bus.jump = 1'b0; bus.halt = 1'b1; bus.resume = 1'b1;
      cyc();
      chk("halt_resume_both_halted", int'(bus.halted), 1);
      bus.halt = 1'b0;
      cyc();
      chk("resume_pc", int'(bus.pc_out), 7);
      chk("resume_fetch_valid", int'(bus.fetch_valid), 1);
      bus.resume = 1'b0; bus.imem_ready = 1'b0;

      // Reset from halt.
      jump_to(30);
      bus.halt = 1'b1;
      cyc();
      bus.halt = 1'b0;
      chk("halt30_halted", int'(bus.halted), 1);
      rst = 1'b1;
      cyc();
      chk("halt_rst_pc", int'(bus.pc_out), 0);
      chk("halt_rst_halted", int'(bus.halted), 0);
      chk("halt_rst_fetch_valid", int'(bus.fetch_valid), 0);
      rst = 1'b0;
      cyc();
      chk("post_rst_run", int'(bus.fetch_valid), 1);

      // Randomized traffic; the model check runs every cycle.
      for (int i = 0; i < 4000; i++) begin
         rst               = ($urandom_range(0, 199) == 0);
         bus.halt          = ($urandom_range(0, 24) == 0);
         bus.resume        = ($urandom_range(0, 3) == 0);
         bus.jump          = ($urandom_range(0, 9) == 0);
         bus.branch_taken  = ($urandom_range(0, 7) == 0);
         bus.stall         = ($urandom_range(0, 4) == 0);
         bus.imem_ready    = ($urandom_range(0, 3) != 0);
         bus.jump_target   = ($urandom_range(0, 3) == 0) ? 6'd62 : PC_W'($urandom_range(0, 63));
         bus.branch_target = PC_W'($urandom_range(0, 63));
         cyc();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and next-PC selector for the fetch stage.
- Holds the current PC and drives it to the PC adder and to instruction memory.
- Chooses the next PC from one of four sources: adder result (pc_plus1), branch target, jump target, or hold.
- Sequenced by a small run/halt state machine and a valid/ready fetch handshake with instruction memory.

Parameters:
- PC_W, 6, PC width in bits; matches the adder datapath.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_plus1  input  PC_W  incremented PC from the PC adder; combinationally equal to pc_out+1.
- branch_taken  input  1  branch redirect request.
- branch_target  input  PC_W  branch destination.
- jump  input  1  jump redirect request.
- jump_target  input  PC_W  jump destination.
- stall  input  1  hold PC (pipeline stall).
- halt  input  1  enter HALT.
- resume  input  1  leave HALT.
- imem_ready  input  1  instruction memory accepts the fetch this cycle.
- pc_out  output  PC_W  current PC; feeds the adder and imem address.
- fetch_valid  output  1  pc_out is a valid fetch request.
- halted  output  1  state is HALT.
- pc_wrap  output  1  one-cycle pulse when the PC advanced from all-ones to 0 through the increment path.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - Any cycle with rst=1 at posedge sets pc_out=RESET_PC, state=IDLE, fetch_valid=0, halted=0, pc_wrap=0.
  - Mid-operation reset discards pending redirects.
- States:
  - IDLE: entered only from reset. fetch_valid=0. Next cycle goes to RUN unconditionally; halt in IDLE is ignored.
  - RUN: fetch_valid=1. Next-PC selection by priority, evaluated at each posedge:
    1. halt=1: PC holds; go to HALT. Any simultaneous redirect or increment is dropped.
    2. jump=1: PC<=jump_target. Applies regardless of stall or imem_ready.
    3. branch_taken=1: PC<=branch_target. Applies regardless of stall or imem_ready. If jump and branch_taken are both 1, jump wins.
    4. stall=1 or imem_ready=0: PC holds.
    5. Otherwise the fetch is accepted: PC<=pc_plus1.
  - HALT: fetch_valid=0, halted=1, PC holds. All redirect and stall inputs are ignored.
    - resume=1 returns to RUN next cycle with the same PC.
    - halt and resume both 1: stay in HALT.
- Handshake: the fetch transfers when fetch_valid && imem_ready && !stall && !halt && !jump && !branch_taken. The PC advances by exactly one per transfer, never otherwise.
- Latency: redirect or increment appears on pc_out one cycle after the sampling edge. There is no combinational path from inputs to pc_out.
- Width and wrap:
  - All PC arithmetic is modulo 2^PC_W. pc_plus1 is taken as-is, truncated to PC_W.
  - pc_wrap=1 for the single cycle after an increment-path update from all-ones (63) to 0.
  - A redirect to 0 does not pulse pc_wrap.
- pc_wrap, halted and fetch_valid are registered (derived from registered state).

Decomposition:
- Shared package holds:
  - PC_W.
  - RESET_PC.
  - State enum IDLE/RUN/HALT, 2-bit encoding.
  - Next-PC source select enum NPC_HOLD/NPC_INC/NPC_BR/NPC_JMP.
- Natural sub-module: pc_next_mux, a combinational priority select producing next_pc and source code.
- The top level holds the state register, PC register and wrap flag.

Test Plan:
- Reset, then 3 cycles of imem_ready=1 → pc_out sequence 0 (IDLE), 0 (RUN), 1, 2; fetch_valid 0,1,1,1.
- pc_out=5 with imem_ready=0 for 2 cycles, then 1 → pc_out stays 5,5 then becomes 6. stall=1 behaves the same.
- pc_out=10; jump=1 (jump_target=40), branch_taken=1 (branch_target=20), and stall=1 all in the same cycle → pc_out=40 next cycle.
- Preload pc_out=63 via jump, then accept a fetch → pc_out=0 and pc_wrap=1 for exactly one cycle. A jump to 0 → pc_wrap stays 0.
- pc_out=7; halt=1 with jump=1 → pc_out=7, halted=1, fetch_valid=0. Then a jump is ignored. Then resume=1 → RUN with pc_out=7.
- In HALT at pc_out=30, assert rst → pc_out=0, state IDLE, halted=0, then RUN the following cycle.
